// File: rtl/demux_3bits_pkg.sv
// Shared sizing constants and helpers for the 3-bit select demux/mux family.
package demux_3bits_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SEL_W     = 3;
  localparam int CNT_W     = 4;

  // Number of set bits in a slot-valid vector; result fits in CNT_W bits (0..8).
  function automatic logic [CNT_W-1:0] popcount_slots(input logic [NUM_SLOTS-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output slot of the demux: a data register plus a valid flag.
// A write in the same cycle as an ack wins, so the slot stays valid with new data.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             valid_next
);

  // Next value of the valid flag: reset, then write, then ack, in priority order.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    valid_next = valid;
    if (ack) begin
      valid_next = 1'b0;
    end
    if (wr_en) begin
      valid_next = 1'b1;
    end
    if (reset) begin
      valid_next = 1'b0;
    end
  end

  // Slot register: data loads only on write and is kept through an ack.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    if (reset) begin
      // NOTE: the data register is cleared on reset because o0..o7 must read zero after reset.
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= valid_next;
      if (wr_en) begin
        data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/demux_3bits.sv
// 1-to-8 registered demux with per-slot valid/ack handshake, occupancy count and drop flag.
module demux_3bits
  import demux_3bits_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     ctrl,
  input  logic [WIDTH-1:0]     in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     o0,
  output logic [WIDTH-1:0]     o1,
  output logic [WIDTH-1:0]     o2,
  output logic [WIDTH-1:0]     o3,
  output logic [WIDTH-1:0]     o4,
  output logic [WIDTH-1:0]     o5,
  output logic [WIDTH-1:0]     o6,
  output logic [WIDTH-1:0]     o7,
  output logic [NUM_SLOTS-1:0] out_valid,
  input  logic [NUM_SLOTS-1:0] out_ack,
  output logic [CNT_W-1:0]     count,
  output logic                 drop
);

  logic [NUM_SLOTS-1:0] wr_en;
  logic [NUM_SLOTS-1:0] valid_next;
  logic [WIDTH-1:0]     slot_data [NUM_SLOTS];
  logic                 accept;

  // The selected slot can take a write if it is empty or being drained this cycle.
  assign in_ready = !out_valid[ctrl] || out_ack[ctrl];
  assign accept   = in_valid && in_ready && !reset;

  // Decode an accepted write onto exactly one slot.
  always_comb begin
    wr_en = '0;
    if (accept) begin
      wr_en[ctrl] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en[k]),
      .wr_data    (in),
      .ack        (out_ack[k]),
      .data       (slot_data[k]),
      .valid      (out_valid[k]),
      .valid_next (valid_next[k])
    );
  end

  assign o0 = slot_data[0];
  assign o1 = slot_data[1];
  assign o2 = slot_data[2];
  assign o3 = slot_data[3];
  assign o4 = slot_data[4];
  assign o5 = slot_data[5];
  assign o6 = slot_data[6];
  assign o7 = slot_data[7];

  // Count tracks the slots' next valid flags so it lines up with out_valid every cycle;
  // drop flags a refused offer for the following cycle only.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      drop  <= 1'b0;
    end else begin
      count <= popcount_slots(valid_next);
      drop  <= in_valid && !in_ready;
    end
  end

endmodule

// File: tb/tb_demux_3bits.sv
// Scoreboard bench for demux_3bits: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_demux_3bits;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ctrl;
  logic [31:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [3:0]  count;
  logic        drop;

  demux_3bits #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .in(in), .in_valid(in_valid),
    .in_ready(in_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .out_valid(out_valid), .out_ack(out_ack), .count(count), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][31:0] data;
    logic [7:0]       valid;
    logic [3:0]       count;
    logic             drop;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: slot contents and flags as plain arrays.
  logic [31:0] m_data [8];
  logic [7:0]  m_valid;
  logic        m_drop;

  logic [31:0] act_o [8];
  assign act_o[0] = o0; assign act_o[1] = o1; assign act_o[2] = o2; assign act_o[3] = o3;
  assign act_o[4] = o4; assign act_o[5] = o5; assign act_o[6] = o6; assign act_o[7] = o7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive, check in_ready, advance the model, push expected state.
  task automatic step(input logic rst, input logic iv, input logic [2:0] c,
                      input logic [31:0] d, input logic [7:0] ack);
    logic ready;
    exp_t e;
    @(negedge clk);
    reset = rst; in_valid = iv; ctrl = c; in = d; out_ack = ack;
    #1;
    ready = !m_valid[c] || ack[c];
    check("in_ready", 32'(in_ready), 32'(ready));
    if (rst) begin
      for (int k = 0; k < 8; k++) m_data[k] = '0;
      m_valid = '0;
      m_drop  = 1'b0;
    end else begin
      m_valid = m_valid & ~ack;
      if (iv && ready) begin
        m_data[c]  = d;
        m_valid[c] = 1'b1;
      end
      m_drop = iv && !ready;
    end
    for (int k = 0; k < 8; k++) e.data[k] = m_data[k];
    e.valid = m_valid;
    e.count = 4'($countones(m_valid));
    e.drop  = m_drop;
    sb_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new registered state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_valid", 32'(out_valid), 32'(e.valid));
        check("count", 32'(count), 32'(e.count));
        check("drop", 32'(drop), 32'(e.drop));
        for (int k = 0; k < 8; k++) check($sformatf("o%0d", k), act_o[k], e.data[k]);
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1; in_valid = 1'b0; ctrl = '0; in = '0; out_ack = '0;
    for (int k = 0; k < 8; k++) m_data[k] = '0;
    m_valid = '0; m_drop = 1'b0;

    // Reset, then single write to slot 5.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 5, 32'hDEADBEEF, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // Fill all slots from empty.
    step(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) step(0, 1, 3'(k), 32'h10 + 32'(k), 8'h00);
    // Refused write to a full slot, then write-with-ack to the same slot.
    step(0, 1, 3, 32'h55, 8'h00);
    step(0, 1, 3, 32'hA5, 8'h08);
    // Ack everything with no write; ack of empty slots has no effect.
    step(0, 0, 0, 0, 8'hFF);
    step(0, 0, 0, 0, 8'hFF);
    // Slots 1 and 6 valid, reset while offering a write.
    step(0, 1, 1, 32'h111, 8'h00);
    step(0, 1, 6, 32'h666, 8'h00);
    step(1, 1, 2, 32'h222, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), $urandom, 8'($urandom & $urandom));
    end
    step(0, 0, 0, 0, 8'h00);

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_3bits.md
DEMUX_3BITS -- requirements
Module: demux_3bits

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of in and of o0..o7.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 ctrl  input  3  SHALL select the destination slot, 0..7, for the current write.
REQ-005 in  input  WIDTH  SHALL carry the write data.
REQ-006 in_valid  input  1  SHALL indicate that a write is offered this cycle.
REQ-007 in_ready  output  1  SHALL indicate that the offered write is accepted this cycle.
REQ-008 o0..o7  output  WIDTH each  SHALL present the registered contents of slots 0..7.
REQ-009 out_valid  output  8  SHALL mark bit k set when slot k holds unconsumed data.
REQ-010 out_ack  input  8  SHALL let the consumer set bit k to consume slot k.
REQ-011 count  output  4  SHALL report the number of set out_valid bits, 0..8.
REQ-012 drop  output  1  SHALL pulse for one cycle after an offered write was refused.

Function
REQ-013 Acceptance SHALL be defined as in_valid=1 and in_ready=1 in the same cycle.
REQ-014 in_ready SHALL be combinational: in_ready = !out_valid[ctrl] | out_ack[ctrl].
REQ-015 On acceptance, slot ctrl SHALL load in and out_valid[ctrl] SHALL become 1 in the next cycle (1-cycle latency).
REQ-016 Non-selected slots SHALL hold their data unchanged during a write.
REQ-017 out_ack[k]=1 with out_valid[k]=1 SHALL clear out_valid[k] next cycle; the data in o_k SHALL be retained.
REQ-018 out_ack[k]=1 with out_valid[k]=0 SHALL have no effect.
REQ-019 Simultaneous acceptance into slot k and out_ack[k]=1 SHALL leave out_valid[k]=1 with the new data; the write wins.
REQ-020 Any number of out_ack bits SHALL be honoured in the same cycle as one write.
REQ-021 count SHALL be registered and equal popcount(out_valid) every cycle; it SHALL never exceed 8 or wrap.
REQ-022 in_valid=1 with in_ready=0 SHALL set drop=1 in the next cycle only, and SHALL leave all slots unchanged.
REQ-023 All ctrl values 0..7 SHALL be legal; no default or error path exists.
REQ-024 Outputs SHALL be glitch-free registered values, except in_ready, which is combinational.

Reset
REQ-025 With reset=1 at a clock edge, o0..o7, out_valid, count and drop SHALL be 0 after that edge.
REQ-026 During reset, in_ready SHALL still follow REQ-014 combinationally, but no write SHALL take effect.
REQ-027 Reset asserted mid-operation SHALL discard pending data; no ack SHALL be required afterwards.

Structure
REQ-028 Slot count (8), select width (3) and the count width (4) SHALL be localparams in a shared include file, also used by the mux_3bits family.
REQ-029 A single sub-module, demux_slot (one WIDTH register with valid flag, write/ack priority), SHALL be instantiated eight times; the top SHALL hold the decode, count and drop logic.

Verification
REQ-030 Reset, then write 0xDEADBEEF with ctrl=5 -> next cycle o5=0xDEADBEEF, out_valid=0x20, count=1, other outputs 0.
REQ-031 Fill slots 0..7 with values 0x10..0x17 in consecutive cycles -> count rises 1..8, and o_k=0x10+k.
REQ-032 Slot 3 valid, offer a write to ctrl=3 with out_ack=0 -> in_ready=0, drop=1 next cycle, o3 unchanged.
REQ-033 Slot 3 valid, offer 0xA5 with ctrl=3 and out_ack=0x08 in the same cycle -> accepted, o3=0xA5, out_valid[3]=1, count unchanged.
REQ-034 All 8 slots valid, out_ack=0xFF with no write -> out_valid=0, count=0 next cycle, data retained.
REQ-035 Slots 1 and 6 valid, assert reset for one cycle while offering a write -> all outputs 0 next cycle, no write lands.
